// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART: parity modes, TX/RX
// state encodings and the parity-bit calculation used by both directions.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Callers zero-extend the payload to 9 bits; the padding does not affect the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input parity_t mode);
    logic x;
    x = ^data;
    return (mode == PAR_ODD) ? ~x : (mode == PAR_EVEN) ? x : 1'b0;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks,
// shared by the transmitter and receiver.
module uart_baud_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART: valid/ready transmitter and oversampled
// receiver with synchroniser, mid-bit start validation and error flags.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned DIV_RAW  = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV      = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned PW       = $clog2(2 * OVERSAMPLE);
  localparam int unsigned IW       = $clog2(DATA_BITS);
  localparam parity_t     PAR_MODE = parity_t'(PARITY[1:0]);
  localparam bit          HAS_PAR  = (PARITY != 0);
  localparam logic [PW-1:0] BIT_END  = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] HALF_END = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] STOP_END = PW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [PW-1:0]        tx_phase, tx_phase_n;
  logic [IW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n, tx_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_phase <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_phase <= tx_phase_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx       <= tx_n;
    end
  end

  // The line is registered: each transition loads the level of the bit being entered.
  always_comb begin
    tx_state_n = tx_state;
    tx_phase_n = tx_phase;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_n       = tx;
    tx_done    = 1'b0;
    tx_ready   = (tx_state == TX_IDLE);
    if (tick && tx_state != TX_IDLE) tx_phase_n = tx_phase + 1'b1;
    case (tx_state)
      TX_IDLE: if (tx_valid) begin
        tx_state_n = TX_START;
        tx_phase_n = '0;
        tx_idx_n   = '0;
        tx_sh_n    = tx_data;
        tx_par_n   = calc_parity(9'(tx_data), PAR_MODE);
        tx_n       = 1'b0;
      end
      TX_START: if (tick && tx_phase == BIT_END) begin
        tx_state_n = TX_DATA;
        tx_phase_n = '0;
        tx_n       = tx_sh[0];
      end
      TX_DATA: if (tick && tx_phase == BIT_END) begin
        tx_phase_n = '0;
        if (tx_idx == LAST_BIT) begin
          tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
          tx_n       = HAS_PAR ? tx_par : 1'b1;
        end else begin
          tx_idx_n = tx_idx + 1'b1;
          tx_sh_n  = tx_sh >> 1;
          tx_n     = tx_sh[1];
        end
      end
      TX_PARITY: if (tick && tx_phase == BIT_END) begin
        tx_state_n = TX_STOP;
        tx_phase_n = '0;
        tx_n       = 1'b1;
      end
      TX_STOP: if (tick && tx_phase == STOP_END) begin
        tx_state_n = TX_IDLE;
        tx_phase_n = '0;
        tx_done    = 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_state_n;
  logic [PW-1:0]        rx_phase, rx_phase_n;
  logic [IW-1:0]        rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_par_bit, rx_par_bit_n;
  logic                 rx_s1, rx_s2, rx_prev, rx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_phase   <= '0;
      rx_idx     <= '0;
      rx_sh      <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_state   <= rx_state_n;
      rx_phase   <= rx_phase_n;
      rx_idx     <= rx_idx_n;
      rx_sh      <= rx_sh_n;
      rx_par_bit <= rx_par_bit_n;
    end
  end

  // Start is armed only by a falling edge, so a held-low break cannot retrigger.
  always_comb begin
    rx_state_n   = rx_state;
    rx_phase_n   = rx_phase;
    rx_idx_n     = rx_idx;
    rx_sh_n      = rx_sh;
    rx_par_bit_n = rx_par_bit;
    rx_done      = 1'b0;
    if (tick && rx_state != RX_IDLE) rx_phase_n = rx_phase + 1'b1;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_s2) begin
        rx_state_n = RX_START;
        rx_phase_n = '0;
        rx_idx_n   = '0;
      end
      RX_START: if (tick && rx_phase == HALF_END) begin
        rx_phase_n = '0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (tick && rx_phase == BIT_END) begin
        rx_phase_n = '0;
        rx_sh_n    = {rx_s2, rx_sh[DATA_BITS-1:1]};
        if (rx_idx == LAST_BIT) rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
        else                    rx_idx_n   = rx_idx + 1'b1;
      end
      RX_PARITY: if (tick && rx_phase == BIT_END) begin
        rx_phase_n   = '0;
        rx_par_bit_n = rx_s2;
        rx_state_n   = RX_STOP;
      end
      RX_STOP: if (tick && rx_phase == BIT_END) begin
        rx_phase_n = '0;
        rx_done    = 1'b1;
        rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid <= rx_done;
      if (rx_done) begin
        rx_data    <= rx_sh;
        parity_err <= HAS_PAR && (rx_par_bit != calc_parity(9'(rx_sh), PAR_MODE));
        frame_err  <= ~rx_s2;
        overrun    <= overrun | rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: three instances (8N1, 7E1, 8N2) at 625 kbaud, with a
// frame-level reference model of the serial line and the received payload.
module tb_uart_core;

  localparam int unsigned CLK_HZ  = 100_000_000;
  localparam int unsigned BAUD    = 625_000;
  localparam int          BIT_CLK = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] tx_valid_v = '0;
  logic [2:0] loop_v = '0;
  logic [2:0] drv_v = '1;
  logic [8:0] txd [3];
  logic [2:0] tx_ready_v, tx_v, tx_done_v, rx_in_v, rx_valid_v, perr_v, ferr_v, ovr_v;
  logic [7:0] rxd_a, rxd_c;
  logic [6:0] rxd_b;
  logic [8:0] rxd [3];

  int total = 0;
  int bad = 0;

  int         c_done[$];
  int         c_rxv[$];
  logic [8:0] c_rxd[$];
  logic       c_perr[$];
  logic       c_ferr[$];
  logic       c_tx[$];

  assign rxd[0]  = {1'b0, rxd_a};
  assign rxd[1]  = {2'b0, rxd_b};
  assign rxd[2]  = {1'b0, rxd_c};
  assign rx_in_v = (loop_v & tx_v) | (~loop_v & drv_v);

  always #5 clk = ~clk;

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
              .STOP_BITS(1), .OVERSAMPLE(16)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_v[0]), .tx_data(txd[0][7:0]),
    .tx_ready(tx_ready_v[0]), .tx(tx_v[0]), .tx_done(tx_done_v[0]), .rx(rx_in_v[0]),
    .rx_valid(rx_valid_v[0]), .rx_data(rxd_a), .parity_err(perr_v[0]),
    .frame_err(ferr_v[0]), .overrun(ovr_v[0]));

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
              .STOP_BITS(1), .OVERSAMPLE(16)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_v[1]), .tx_data(txd[1][6:0]),
    .tx_ready(tx_ready_v[1]), .tx(tx_v[1]), .tx_done(tx_done_v[1]), .rx(rx_in_v[1]),
    .rx_valid(rx_valid_v[1]), .rx_data(rxd_b), .parity_err(perr_v[1]),
    .frame_err(ferr_v[1]), .overrun(ovr_v[1]));

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
              .STOP_BITS(2), .OVERSAMPLE(16)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_v[2]), .tx_data(txd[2][7:0]),
    .tx_ready(tx_ready_v[2]), .tx(tx_v[2]), .tx_done(tx_done_v[2]), .rx(rx_in_v[2]),
    .rx_valid(rx_valid_v[2]), .rx_data(rxd_c), .parity_err(perr_v[2]),
    .frame_err(ferr_v[2]), .overrun(ovr_v[2]));

  // ---- reference model: frame layout derived from the configuration ----
  function automatic int db(input int s);
    return (s == 1) ? 7 : 8;
  endfunction

  function automatic int pm(input int s);
    return (s == 1) ? 2 : 0;
  endfunction

  function automatic int sb(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  function automatic int nbits(input int s);
    return 1 + db(s) + ((pm(s) != 0) ? 1 : 0) + sb(s);
  endfunction

  function automatic logic par_of(input logic [8:0] d, input int s);
    int ones = 0;
    for (int i = 0; i < db(s); i++) ones += int'(d[i]);
    if (pm(s) == 2) return (ones % 2) == 1;
    if (pm(s) == 1) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic exp_bit(input logic [8:0] d, input int s, input int i);
    if (i == 0) return 1'b0;
    if (i <= db(s)) return d[i-1];
    if (pm(s) != 0 && i == db(s) + 1) return par_of(d, s);
    return 1'b1;
  endfunction

  function automatic logic [8:0] mask_of(input int s, input logic [8:0] d);
    return d & ((9'd1 << db(s)) - 9'd1);
  endfunction

  // ---- helpers (stimulus and observation only) ----
  task automatic capture(input int s, input int n);
    c_done.delete(); c_rxv.delete(); c_rxd.delete();
    c_perr.delete(); c_ferr.delete(); c_tx.delete();
    for (int c = 0; c < n; c++) begin
      c_tx.push_back(tx_v[s]);
      if (tx_done_v[s]) c_done.push_back(c);
      if (rx_valid_v[s]) begin
        c_rxv.push_back(c);
        c_rxd.push_back(rxd[s]);
        c_perr.push_back(perr_v[s]);
        c_ferr.push_back(ferr_v[s]);
      end
      @(negedge clk);
    end
  endtask

  task automatic drive_frame(input int s, input logic [8:0] d, input bit flip_par, input bit stop_lvl);
    logic b;
    for (int i = 0; i < nbits(s); i++) begin
      b = exp_bit(d, s, i);
      if (flip_par && pm(s) != 0 && i == db(s) + 1) b = ~b;
      if (i == db(s) + 1 + ((pm(s) != 0) ? 1 : 0)) b = stop_lvl;
      drv_v[s] = b;
      repeat (BIT_CLK) @(negedge clk);
    end
    drv_v[s] = 1'b1;
  endtask

  task automatic wait_ready(input int s);
    int n = 0;
    while (!tx_ready_v[s] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_ready_v[s] !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready[%0d]: tx_ready=%b required 1 within 5000 cycles", s, tx_ready_v[s]);
    end
  endtask

  // ---- scenarios ----
  task automatic send_check(input int s, input logic [8:0] d_in, input string tag);
    logic [8:0]  d;
    logic [15:0] got, want;
    int nb, lead, e;
    bit ok;
    d  = mask_of(s, d_in);
    nb = nbits(s);
    wait_ready(s);
    loop_v[s] = 1'b1;
    txd[s] = d;
    tx_valid_v[s] = 1'b1;
    @(negedge clk);
    tx_valid_v[s] = 1'b0;
    total++;
    if (tx_v[s] !== 1'b0) begin
      bad++;
      $display("FAIL %s tx_latency: tx=%b required 0", tag, tx_v[s]);
    end
    capture(s, nb * BIT_CLK + 40);
    got = '0;
    want = '0;
    for (int i = 0; i < nb; i++) begin
      got[i]  = c_tx[i * BIT_CLK + 75];
      want[i] = exp_bit(d, s, i);
    end
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s tx_bits: line=%h required %h (data %h)", tag, got, want, d);
    end
    if (d[0]) begin
      lead = 0;
      while (lead < c_tx.size() && c_tx[lead] == 1'b0) lead++;
      total++;
      if (lead < 150 || lead > 161) begin
        bad++;
        $display("FAIL %s start_len: %0d clk required 150..161", tag, lead);
      end
    end
    ok = (c_done.size() == 1);
    if (ok) begin
      e  = c_done[0] + 1 - nb * BIT_CLK;
      ok = (e >= -10 && e <= 10);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s tx_done: pulses=%0d at=%0d required 1 near %0d", tag, c_done.size(),
               (c_done.size() > 0) ? c_done[0] + 1 : -1, nb * BIT_CLK);
    end
    ok = (c_rxv.size() == 1);
    if (ok) ok = (c_rxd[0] === d) && (c_perr[0] === 1'b0) && (c_ferr[0] === 1'b0);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s rx_frame: valids=%0d data=%h perr=%b ferr=%b required 1/%h/0/0", tag,
               c_rxv.size(), (c_rxd.size() > 0) ? c_rxd[0] : 9'h1FF,
               (c_perr.size() > 0) ? c_perr[0] : 1'bx, (c_ferr.size() > 0) ? c_ferr[0] : 1'bx, d);
    end
  endtask

  task automatic rx_inject(input int s, input logic [8:0] d_in, input bit flip, input bit stop_lvl,
                           input string tag);
    logic [8:0] d;
    logic exp_perr, exp_ferr;
    bit ok;
    d = mask_of(s, d_in);
    exp_perr = flip && (pm(s) != 0);
    exp_ferr = !stop_lvl;
    loop_v[s] = 1'b0;
    drv_v[s] = 1'b1;
    repeat (20) @(negedge clk);
    fork
      drive_frame(s, d, flip, stop_lvl);
      capture(s, nbits(s) * BIT_CLK + 200);
    join
    ok = (c_rxv.size() == 1);
    if (ok) ok = (c_rxd[0] === d) && (c_perr[0] === exp_perr) && (c_ferr[0] === exp_ferr);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s rx_inject: valids=%0d data=%h perr=%b ferr=%b required 1/%h/%b/%b", tag,
               c_rxv.size(), (c_rxd.size() > 0) ? c_rxd[0] : 9'h1FF,
               (c_perr.size() > 0) ? c_perr[0] : 1'bx, (c_ferr.size() > 0) ? c_ferr[0] : 1'bx,
               d, exp_perr, exp_ferr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      total++;
      if ({tx_v[s], tx_ready_v[s], tx_done_v[s], rx_valid_v[s], perr_v[s], ferr_v[s], ovr_v[s]}
          !== 7'b1100000) begin
        bad++;
        $display("FAIL reset_flags[%0d]: tx,rdy,done,rxv,perr,ferr,ovr=%b required 1100000", s,
                 {tx_v[s], tx_ready_v[s], tx_done_v[s], rx_valid_v[s], perr_v[s], ferr_v[s], ovr_v[s]});
      end
      total++;
      if (rxd[s] !== 9'h000) begin
        bad++;
        $display("FAIL reset_rx_data[%0d]: %h required 000", s, rxd[s]);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback_8n1();
    send_check(0, 9'h0A5, "a5_8n1");
    for (int i = 0; i < 3; i++) send_check(0, 9'($urandom_range(0, 255)), "rand_8n1");
  endtask

  task automatic test_parity();
    send_check(1, 9'h055, "p55_7e1");
    send_check(1, 9'($urandom_range(0, 127)), "rand_7e1");
    rx_inject(1, 9'h055, 1'b1, 1'b1, "flip_par");
    rx_inject(1, 9'($urandom_range(0, 127)), 1'b0, 1'b1, "good_par");
  endtask

  task automatic test_back_to_back();
    int r, f, nb;
    bit ok;
    nb = nbits(2);
    wait_ready(2);
    loop_v[2] = 1'b1;
    txd[2] = 9'h000;
    tx_valid_v[2] = 1'b1;
    @(negedge clk);
    txd[2] = 9'h0FF;
    fork
      capture(2, 2 * nb * BIT_CLK + 200);
      begin
        int n = 0;
        @(negedge clk);
        while (!tx_ready_v[2] && n < 4000) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        tx_valid_v[2] = 1'b0;
      end
    join
    r = 0;
    while (r < c_tx.size() && c_tx[r] == 1'b0) r++;
    f = r;
    while (f < c_tx.size() && c_tx[f] == 1'b1) f++;
    total++;
    if (f - r < 320 || f - r > 321) begin
      bad++;
      $display("FAIL b2b_gap: stop-to-start %0d clk required 320..321", f - r);
    end
    total++;
    if (c_done.size() != 2) begin
      bad++;
      $display("FAIL b2b_tx_done: pulses=%0d required 2", c_done.size());
    end
    ok = (c_rxv.size() == 2);
    if (ok) ok = (c_rxd[0] === 9'h000) && (c_rxd[1] === 9'h0FF) && !c_ferr[0] && !c_ferr[1];
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_rx: valids=%0d first=%h second=%h required 2/000/0ff", c_rxv.size(),
               (c_rxd.size() > 0) ? c_rxd[0] : 9'h1FF, (c_rxd.size() > 1) ? c_rxd[1] : 9'h1FF);
    end
  endtask

  task automatic test_glitch();
    loop_v[0] = 1'b0;
    drv_v[0] = 1'b1;
    repeat (20) @(negedge clk);
    drv_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    drv_v[0] = 1'b1;
    capture(0, 400);
    total++;
    if (c_rxv.size() != 0) begin
      bad++;
      $display("FAIL glitch: rx_valid pulses=%0d required 0", c_rxv.size());
    end
    rx_inject(0, 9'($urandom_range(0, 255)), 1'b0, 1'b1, "post_glitch");
  endtask

  task automatic test_frame_err();
    bit ok;
    rx_inject(0, 9'h03C, 1'b0, 1'b0, "stop_low");
    drv_v[0] = 1'b0;
    capture(0, 3000);
    drv_v[0] = 1'b1;
    ok = (c_rxv.size() == 1);
    if (ok) ok = (c_rxd[0] === 9'h000) && (c_ferr[0] === 1'b1);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL break: valids=%0d data=%h ferr=%b required 1/000/1", c_rxv.size(),
               (c_rxd.size() > 0) ? c_rxd[0] : 9'h1FF, (c_ferr.size() > 0) ? c_ferr[0] : 1'bx);
    end
    rx_inject(0, 9'($urandom_range(0, 255)), 1'b0, 1'b1, "post_break");
  endtask

  task automatic test_reset_mid();
    wait_ready(0);
    loop_v[0] = 1'b1;
    txd[0] = 9'($urandom_range(0, 255));
    tx_valid_v[0] = 1'b1;
    @(negedge clk);
    tx_valid_v[0] = 1'b0;
    repeat (4 * BIT_CLK + 80) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx_v[0], tx_ready_v[0]} !== 2'b11) begin
      bad++;
      $display("FAIL reset_mid: tx=%b tx_ready=%b required 1/1", tx_v[0], tx_ready_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture(0, 2000);
    total++;
    if (c_rxv.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_rx: rx_valid pulses=%0d required 0", c_rxv.size());
    end
    send_check(0, 9'h081, "after_rst");
  endtask

  task automatic test_overrun();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (ovr_v[s] !== 1'b0) begin
        bad++;
        $display("FAIL overrun[%0d]: %b required 0", s, ovr_v[s]);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) txd[s] = '0;
    test_reset();
    test_loopback_8n1();
    test_parity();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
